// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// onto a single 8-bit RAM port with one-cycle read latency.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_sig,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_sig,
  input  logic        load_or_store,
  input  logic [2:0]  len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] store_val,
  output logic        ls_done,
  output logic [31:0] ls_data
);

  typedef enum logic [2:0] {
    IDLE, IF_RD, LS_RD, LS_WR, DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] base, wdata, rbuf, rbuf_nx;
  logic [31:0] a_q, cur_a;
  logic [2:0]  cnt, nbytes, nlen;
  logic [1:0]  bi;
  logic        is_ls, stall, last_rd, last_wr;

  assign cur_a   = base + {29'd0, cnt};
  assign stall   = io_buffer_full &&
                   (cur_a == 32'h0003_0000 ||
                    cur_a == 32'h0003_0004);
  assign last_rd = cnt == nbytes;
  assign last_wr = cnt == nbytes - 3'd1;
  assign bi      = cnt[1:0] - 2'd1;
  assign rbuf_nx = rbuf |
                   ({24'd0, mem_din} << {bi, 3'b000});
  assign if_done = state == DONE && !is_ls;
  assign ls_done = state == DONE && is_ls;

  always_comb begin
    nlen = 3'd1;
    unique case (1'b1)
      len[2]:  nlen = 3'd4;
      len[1]:  nlen = 3'd2;
      len[0]:  nlen = 3'd1;
      default: nlen = 3'd1;
    endcase
  end

  // While frozen, keep presenting the previous address so mem_din
  // still carries the byte the next capture expects on resume.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (!rdy) begin
      mem_a = a_q;
    end else begin
      unique case (state)
        IF_RD, LS_RD: begin
          if (!last_rd) mem_a = cur_a;
        end
        LS_WR: begin
          mem_a  = cur_a;
          mem_wr = !stall;
          unique case (cnt[1:0])
            2'd0: mem_dout = wdata[7:0];
            2'd1: mem_dout = wdata[15:8];
            2'd2: mem_dout = wdata[23:16];
            2'd3: mem_dout = wdata[31:24];
            default: mem_dout = 8'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!clear) begin
          if (ls_sig)
            state_nx = load_or_store ? LS_WR : LS_RD;
          else if (if_sig)
            state_nx = IF_RD;
        end
      end
      IF_RD, LS_RD: begin
        if (clear)        state_nx = IDLE;
        else if (last_rd) state_nx = DONE;
      end
      LS_WR: begin
        if (!stall && last_wr) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base    <= 32'd0;
      wdata   <= 32'd0;
      rbuf    <= 32'd0;
      a_q     <= 32'd0;
      cnt     <= 3'd0;
      nbytes  <= 3'd0;
      is_ls   <= 1'b0;
      if_data <= 32'd0;
      ls_data <= 32'd0;
    end else if (rdy) begin
      a_q <= mem_a;
      unique case (state)
        IDLE: begin
          if (state_nx != IDLE) begin
            base   <= ls_sig ? ls_addr : if_addr;
            wdata  <= store_val;
            nbytes <= ls_sig ? nlen : 3'd4;
            is_ls  <= ls_sig;
            cnt    <= 3'd0;
            rbuf   <= 32'd0;
          end
        end
        IF_RD, LS_RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rbuf <= rbuf_nx;
          if (state_nx == DONE) begin
            if (is_ls) ls_data <= rbuf_nx;
            else       if_data <= rbuf_nx;
          end
        end
        LS_WR: begin
          if (!stall) cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-low reset; sampled on clk rising edge only.
REQ-003 rdy  in  1  global enable; low = freeze all state.
REQ-004 clear  in  1  pipeline flush.
REQ-005 mem_din  in  8  RAM read byte.
REQ-006 mem_dout  out  8  RAM write byte.
REQ-007 mem_a  out  32  RAM byte address.
REQ-008 mem_wr  out  1  1 = write, 0 = read.
REQ-009 io_buffer_full  in  1  UART buffer full.
REQ-010 if_sig  in  1  instruction fetch request.
REQ-011 if_addr  in  32  fetch address.
REQ-012 if_done  out  1  fetch complete pulse.
REQ-013 if_data  out  32  fetched instruction.
REQ-014 ls_sig  in  1  load/store request.
REQ-015 load_or_store  in  1  0 load, 1 store.
REQ-016 len  in  3  byte count, one-hot: 001/010/100 = 1/2/4 bytes.
REQ-017 ls_addr  in  32  load/store address.
REQ-018 store_val  in  32  store data, low bytes used.
REQ-019 ls_done  out  1  load/store complete pulse.
REQ-020 ls_data  out  32  load data, zero-filled above len bytes.

Function
REQ-021 FSM states IDLE, IF_RD, LS_RD, LS_WR, DONE; byte-serial, little-endian, byte i at base+i.
REQ-022 In IDLE, at edge E0: ls_sig high -> LS_RD/LS_WR per load_or_store; else if_sig high -> IF_RD; ls has priority; request fields latched at E0.
REQ-023 RAM timing: mem_din during cycle c+1 holds byte addressed in cycle c; cycle i = cycle after edge E_i.
REQ-024 Read of n bytes: mem_a = base+i, mem_wr=0 in cycle i (i<n); byte i captured at E_{i+2}; done high in cycle n+1 with assembled data.
REQ-025 IF_RD always n=4; if_done high cycle 5; if_data valid while if_done high.
REQ-026 Write of n bytes: cycle i drives mem_a=base+i, mem_dout=store_val[8i+7:8i], mem_wr=1; ls_done high cycle n.
REQ-027 Write to 0x30000 or 0x30004 while io_buffer_full high: hold current byte with mem_wr=0; resume when low; done delayed by stall count.
REQ-028 Done pulses exactly one cycle (DONE state); no request accepted in DONE; return to IDLE next edge.
REQ-029 mem_wr=0 in every non-write cycle.
REQ-030 clear high at an edge during IF_RD or LS_RD: abort to IDLE, no done pulse, even if that edge would complete the read.
REQ-031 clear never aborts LS_WR; store completes and ls_done pulses.
REQ-032 clear high in IDLE: no request accepted that edge.
REQ-033 rdy low: FSM, counters and captured bytes hold; mem_wr forced 0; done outputs hold value.
REQ-034 Address increment 32-bit wrapping; 0xFFFFFFFF+1 = 0.
REQ-035 Requester deasserts sig on edge that samples done; block does not re-check sig until IDLE.

Reset
REQ-036 rst low at edge: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_data=0; byte counter and latched request cleared.
REQ-037 Reset mid-write: write abandoned, mem_wr=0 next cycle; no done pulse.
REQ-038 Reset dominates rdy and clear.

Verification
REQ-039 RAM[0x100..0x103]=13,00,50,00; if_sig, if_addr=0x100 -> if_done cycle 5, if_data=0x00500013.
REQ-040 ls_sig and if_sig same edge, LW 0x200 (RAM 0xDEADBEEF) -> ls_done cycle 5, ls_data=0xDEADBEEF; IF starts after DONE.
REQ-041 SH 0x300, store_val=0x1234ABCD -> cycle0 0xCD@0x300, cycle1 0xAB@0x301, mem_wr=1; ls_done cycle 2.
REQ-042 SB 0x30000, io_buffer_full high 3 cycles -> mem_wr=0 those cycles; byte written after; ls_done 3 cycles late.
REQ-043 IF_RD, clear high at E3 -> IDLE, no if_done; LS_WR with clear -> ls_done still pulses.
REQ-044 rdy low 2 cycles mid-LW -> ls_done 2 cycles late, data correct; rst low mid-SW -> mem_wr=0, no ls_done.
